// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// - alu_op_e: the 3-bit alu_control encoding, shared with the control decoder.
// - alu_exec_state_e: execute-unit FSM states.
// - is_shift_op(): true for the ops that may take the iterative shift path.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLL = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SRL = 3'b110,
        ALU_ILL = 3'b111
    } alu_op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } alu_exec_state_e;

    function automatic logic is_shift_op(input alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: add/sub/and/or/slt, plus a barrel shifter
// when ALU_EXEC_FAST_SHIFT_EN is defined.
// Ports:
//   op_i      - decoded ALU operation
//   a_i, b_i  - operands (b_i[SHW-1:0] is the shift amount)
//   result_o  - combinational result
//   illegal_o - op was the reserved code 111
// Without ALU_EXEC_FAST_SHIFT_EN, shifts return a_i unchanged; the caller only
// uses that value when the shift amount is zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  alu_op_e          op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    output logic [XLEN-1:0]  result_o,
    output logic             illegal_o
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic slt_lt;
    assign slt_lt = $signed(a_i) < $signed(b_i);

    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        unique case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SLT: result_o = {{(XLEN-1){1'b0}}, slt_lt};
`ifdef ALU_EXEC_FAST_SHIFT_EN
            ALU_SLL: result_o = a_i << b_i[SHW-1:0];
            ALU_SRL: result_o = a_i >> b_i[SHW-1:0];
`else
            ALU_SLL: result_o = a_i;
            ALU_SRL: result_o = a_i;
`endif
            ALU_ILL: begin
                result_o  = '0;
                illegal_o = 1'b1;
            end
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: accepts an op and two operands over a valid/ready
// handshake and produces a registered result, zero flag and illegal flag.
// Single-cycle ops complete on the accept edge; sll/srl with a nonzero shift
// amount iterate one bit per cycle in the SHIFT state.
// Configuration: define ALU_EXEC_FAST_SHIFT_EN to use a barrel shifter instead,
// in which case the SHIFT state is never entered.
// Ports:
//   clk_i, rst_ni                    - clock, async active-low reset
//   flush_i                          - synchronous abort of in-flight op and held result
//   in_valid_i / in_ready_o          - input handshake
//   alu_control_i, op_a_i, op_b_i    - op code and operands
//   out_valid_o / out_ready_i        - output handshake
//   out_result_o, out_zero_o, out_illegal_o - registered result and flags
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       alu_control_i,
    input  logic [XLEN-1:0]  op_a_i,
    input  logic [XLEN-1:0]  op_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_result_o,
    output logic             out_zero_o,
    output logic             out_illegal_o
);

    localparam int unsigned SHW = $clog2(XLEN);

`ifdef ALU_EXEC_FAST_SHIFT_EN
    localparam bit FastShift = 1'b1;
`else
    localparam bit FastShift = 1'b0;
`endif

    alu_exec_state_e state_q, state_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            shl_q, shl_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic            valid_q, valid_d;

    alu_op_e         op;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] core_result;
    logic            core_illegal;
    logic [XLEN-1:0] shifted;
    logic            accept;
    logic            start_shift;

    assign op    = alu_op_e'(alu_control_i);
    assign shamt = op_b_i[SHW-1:0];

    alu_core #(
        .XLEN(XLEN)
    ) u_core (
        .op_i      (op),
        .a_i       (op_a_i),
        .b_i       (op_b_i),
        .result_o  (core_result),
        .illegal_o (core_illegal)
    );

    assign in_ready_o  = (state_q == IDLE) && (!valid_q || out_ready_i) && !flush_i;
    assign accept      = in_valid_i && in_ready_o;
    assign start_shift = accept && is_shift_op(op) && (shamt != '0) && !FastShift;
    assign shifted     = shl_q ? (work_q << 1) : (work_q >> 1);

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        shl_d     = shl_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        valid_d   = valid_q;

        if (flush_i) begin
            // Flush wins over accept and over a completing shift.
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            if (valid_q && out_ready_i) begin
                valid_d = 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (start_shift) begin
                        work_d  = op_a_i;
                        cnt_d   = shamt;
                        shl_d   = (op == ALU_SLL);
                        state_d = SHIFT;
                    end else if (accept) begin
                        result_d  = core_result;
                        zero_d    = (core_result == '0);
                        illegal_d = core_illegal;
                        valid_d   = 1'b1;
                    end
                end
                SHIFT: begin
                    work_d = shifted;
                    cnt_d  = cnt_q - SHW'(1);
                    // Output is always empty here: accept required it empty or draining.
                    if (cnt_q == SHW'(1)) begin
                        result_d  = shifted;
                        zero_d    = (shifted == '0);
                        illegal_d = 1'b0;
                        valid_d   = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            shl_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            shl_q     <= shl_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            valid_q   <= valid_d;
        end
    end

    assign out_valid_o   = valid_q;
    assign out_result_o  = result_q;
    assign out_zero_o    = zero_q;
    assign out_illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: a cycle-level reference model of the
// handshake plus directed vectors with hand-computed results and latencies.
module tb_alu_exec_unit;

`ifdef ALU_EXEC_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [2:0]  alu_control_i = 3'b000;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] out_result_o;
    logic        out_zero_o;
    logic        out_illegal_o;

    int n_total = 0;
    int n_bad = 0;

    alu_exec_unit #(
        .XLEN(32)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .alu_control_i (alu_control_i),
        .op_a_i        (op_a_i),
        .op_b_i        (op_b_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_result_o  (out_result_o),
        .out_zero_o    (out_zero_o),
        .out_illegal_o (out_illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an op, computed directly (shifts in one step).
    function automatic logic [31:0] ref_calc(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b100:  return a << b[4:0];
            3'b110:  return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: m_busy counts remaining shift cycles before the result appears.
    bit          m_valid = 1'b0;
    logic [31:0] m_res = '0;
    bit          m_zero = 1'b0;
    bit          m_ill = 1'b0;
    int          m_busy = 0;
    logic [31:0] m_pend = '0;

    function automatic bit m_ready();
        return (m_busy == 0) && (!m_valid || out_ready_i) && !flush_i;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        bit          nv;
        logic [31:0] nr;
        bit          nz;
        bit          ni;
        int          nb;
        logic [31:0] np;
        logic [31:0] r;
        if (!rst_ni) begin
            m_valid <= 1'b0;
            m_res   <= '0;
            m_zero  <= 1'b0;
            m_ill   <= 1'b0;
            m_busy  <= 0;
        end else begin
            nv = m_valid; nr = m_res; nz = m_zero; ni = m_ill; nb = m_busy; np = m_pend;
            if (flush_i) begin
                nv = 1'b0;
                nb = 0;
            end else begin
                if (m_valid && out_ready_i) nv = 1'b0;
                if (m_busy != 0) begin
                    nb = m_busy - 1;
                    if (nb == 0) begin
                        nv = 1'b1; nr = m_pend; nz = (m_pend == 0); ni = 1'b0;
                    end
                end else if (in_valid_i && m_ready()) begin
                    r = ref_calc(alu_control_i, op_a_i, op_b_i);
                    if ((alu_control_i == 3'b100 || alu_control_i == 3'b110) &&
                        op_b_i[4:0] != 0 && !FAST) begin
                        nb = int'(op_b_i[4:0]);
                        np = r;
                    end else begin
                        nv = 1'b1; nr = r; nz = (r == 0); ni = (alu_control_i == 3'b111);
                    end
                end
            end
            m_valid <= nv; m_res <= nr; m_zero <= nz; m_ill <= ni; m_busy <= nb; m_pend <= np;
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni) begin
            chk("model_in_ready", {31'b0, in_ready_o}, {31'b0, m_ready()});
            chk("model_out_valid", {31'b0, out_valid_o}, {31'b0, m_valid});
            if (m_valid) begin
                chk("model_result", out_result_o, m_res);
                chk("model_zero", {31'b0, out_zero_o}, {31'b0, m_zero});
                chk("model_illegal", {31'b0, out_illegal_o}, {31'b0, m_ill});
            end
        end
    end

    // Present an op and hold it until the accept edge; returns just after that edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        @(posedge clk_i); #1;
        in_valid_i = 1'b1; alu_control_i = op; op_a_i = a; op_b_i = b;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_seen", {31'b0, ok}, 32'd1);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    // Latency counts clock edges from the accept edge (1 = next cycle); 0 on timeout.
    task automatic wait_res(input int max, output int lat, output int busy);
        lat = 0; busy = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk_i);
            if (!in_ready_o) busy++;
            if (out_valid_o) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int busy;
        int seen;

        // Reset values
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_in_ready", {31'b0, in_ready_o}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
        chk("rst_result", out_result_o, 32'd0);
        chk("rst_zero", {31'b0, out_zero_o}, 32'd0);
        chk("rst_illegal", {31'b0, out_illegal_o}, 32'd0);
        @(negedge clk_i); rst_ni = 1'b1;

        // add 5+7
        issue(3'b000, 32'd5, 32'd7);
        wait_res(10, lat, busy);
        chk("add_lat", lat, 32'd1);
        chk("add_res", out_result_o, 32'd12);
        chk("add_zero", {31'b0, out_zero_o}, 32'd0);

        // add wraps
        issue(3'b000, 32'hFFFF_FFFF, 32'd1);
        wait_res(10, lat, busy);
        chk("add_wrap_res", out_result_o, 32'd0);
        chk("add_wrap_zero", {31'b0, out_zero_o}, 32'd1);

        // and / or
        issue(3'b010, 32'h0000_F0F0, 32'h0000_FF00);
        wait_res(10, lat, busy);
        chk("and_res", out_result_o, 32'h0000_F000);
        issue(3'b011, 32'h0000_F0F0, 32'h0000_FF00);
        wait_res(10, lat, busy);
        chk("or_res", out_result_o, 32'h0000_FFF0);

        // sub 9-9 then slt -1<1 back-to-back
        @(posedge clk_i); #1;
        in_valid_i = 1'b1; alu_control_i = 3'b001; op_a_i = 32'd9; op_b_i = 32'd9;
        @(negedge clk_i);
        chk("b2b_ready1", {31'b0, in_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        alu_control_i = 3'b101; op_a_i = 32'hFFFF_FFFF; op_b_i = 32'd1;
        @(negedge clk_i);
        chk("b2b_sub_res", out_result_o, 32'd0);
        chk("b2b_sub_zero", {31'b0, out_zero_o}, 32'd1);
        chk("b2b_ready2", {31'b0, in_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("b2b_slt_valid", {31'b0, out_valid_o}, 32'd1);
        chk("b2b_slt_res", out_result_o, 32'd1);
        chk("b2b_slt_zero", {31'b0, out_zero_o}, 32'd0);

        // sll 1 by 4
        issue(3'b100, 32'd1, 32'd4);
        wait_res(50, lat, busy);
        chk("sll_lat", lat, FAST ? 32'd1 : 32'd5);
        chk("sll_busy", busy, FAST ? 32'd0 : 32'd4);
        chk("sll_res", out_result_o, 32'h10);

        // srl 0x8000_0000 by 31
        issue(3'b110, 32'h8000_0000, 32'd31);
        wait_res(60, lat, busy);
        chk("srl_lat", lat, FAST ? 32'd1 : 32'd32);
        chk("srl_res", out_result_o, 32'd1);

        // shamt field zero (b=32) completes in one cycle with A unchanged
        issue(3'b100, 32'hABCD_0123, 32'd32);
        wait_res(10, lat, busy);
        chk("sll0_lat", lat, 32'd1);
        chk("sll0_res", out_result_o, 32'hABCD_0123);

        // illegal code
        issue(3'b111, 32'd5, 32'd6);
        wait_res(10, lat, busy);
        chk("ill_res", out_result_o, 32'd0);
        chk("ill_flag", {31'b0, out_illegal_o}, 32'd1);
        issue(3'b000, 32'd1, 32'd1);
        wait_res(10, lat, busy);
        chk("ill_clear", {31'b0, out_illegal_o}, 32'd0);

        // Hold with out_ready=0, then release and accept in the same cycle
        @(posedge clk_i); #1; out_ready_i = 1'b0;
        issue(3'b000, 32'd3, 32'd4);
        wait_res(10, lat, busy);
        chk("hold_first", out_result_o, 32'd7);
        @(posedge clk_i); #1;
        in_valid_i = 1'b1; alu_control_i = 3'b011; op_a_i = 32'hF0; op_b_i = 32'h0F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("hold_res", out_result_o, 32'd7);
            chk("hold_valid", {31'b0, out_valid_o}, 32'd1);
            chk("hold_ready", {31'b0, in_ready_o}, 32'd0);
        end
        @(posedge clk_i); #1; out_ready_i = 1'b1;
        @(negedge clk_i);
        chk("release_ready", {31'b0, in_ready_o}, 32'd1);
        @(posedge clk_i); #1; in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("release_res", out_result_o, 32'hFF);

        // flush during sll by 10
        issue(3'b100, 32'd1, 32'd10);
        @(posedge clk_i);
        @(posedge clk_i); #1; flush_i = 1'b1;
        @(negedge clk_i);
        chk("flush_ready_low", {31'b0, in_ready_o}, 32'd0);
        @(posedge clk_i); #1; flush_i = 1'b0;
        @(negedge clk_i);
        chk("flush_ready_next", {31'b0, in_ready_o}, 32'd1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            if (out_valid_o) seen++;
        end
        chk("flush_no_valid", seen, 32'd0);

        // async reset mid-SHIFT
        issue(3'b100, 32'd3, 32'd8);
        @(posedge clk_i);
        @(posedge clk_i); #2; rst_ni = 1'b0;
        #1;
        chk("arst_valid", {31'b0, out_valid_o}, 32'd0);
        chk("arst_ready", {31'b0, in_ready_o}, 32'd1);
        chk("arst_res", out_result_o, 32'd0);
        @(posedge clk_i); #1; rst_ni = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (out_valid_o) seen++;
        end
        chk("arst_no_valid", seen, 32'd0);

        // unit still works after reset
        issue(3'b001, 32'd2, 32'd5);
        wait_res(10, lat, busy);
        chk("post_rst_sub", out_result_o, 32'hFFFF_FFFD);

        repeat (2) @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
